core_dispatch_scoreboard: RTL

- Tracks which architectural registers have writes in flight in each execution unit (EU).
- Produces the per-EU pending-write masks that the dispatch hazard logic consumes: mask_alu_a, mask_alu_b, mask_branch, mask_ldst, plus mask_mul for the new multiplier EU.
- Owns the structural-occupancy state: load/store outstanding queue (drives ldst_wait) and multiplier latency counter (drives mul_busy and mul writeback).
- Sits between dispatch (issue side) and the EU writeback paths.

---
 rtl/core_dispatch_scoreboard.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/core_dispatch_scoreboard.sv
// Pending-write scoreboard between dispatch and the execution units: per-EU
// destination masks, load/store queue occupancy and multiplier latency tracking.
module core_dispatch_scoreboard #(
  parameter int NREGS       = 16,
  parameter int LDST_DEPTH  = 2,
  parameter int MUL_LATENCY = 3,
  localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_a_valid,
  input  logic [2:0]       issue_a_unit,
  input  logic             issue_a_wb,
  input  logic [RW-1:0]    issue_a_rd,
  input  logic             issue_b_valid,
  input  logic [2:0]       issue_b_unit,
  input  logic             issue_b_wb,
  input  logic [RW-1:0]    issue_b_rd,
  input  logic             done_alu_a,
  input  logic             done_alu_b,
  input  logic             done_branch,
  input  logic             done_ldst,
  output logic [NREGS-1:0] mask_alu_a,
  output logic [NREGS-1:0] mask_alu_b,
  output logic [NREGS-1:0] mask_branch,
  output logic [NREGS-1:0] mask_ldst,
  output logic [NREGS-1:0] mask_mul,
  output logic             ldst_wait,
  output logic             mul_busy,
  output logic             mul_wb_valid,
  output logic [RW-1:0]    mul_wb_rd
);
  localparam int PW = (LDST_DEPTH > 1) ? $clog2(LDST_DEPTH) : 1;
  localparam int CW = $clog2(LDST_DEPTH + 1);
  localparam int MW = $clog2(MUL_LATENCY + 1);

  // Per-unit view of this cycle's issue, whichever port carries it.
  logic [4:0]       iss_v;
  logic [4:0]       iss_wb;
  logic [RW-1:0]    iss_rd [5];
  logic [2:0]       done_s;
  logic [NREGS-1:0] ent_mask [3];

  assign done_s = {done_branch, done_alu_b, done_alu_a};

  for (genvar gi = 0; gi < 5; gi++) begin : g_sel
    logic hit_a;
    logic hit_b;
    assign hit_a      = issue_a_valid && (issue_a_unit == 3'(gi));
    assign hit_b      = issue_b_valid && (issue_b_unit == 3'(gi));
    assign iss_v[gi]  = hit_a || hit_b;
    assign iss_wb[gi] = hit_a ? issue_a_wb : issue_b_wb;
    assign iss_rd[gi] = hit_a ? issue_a_rd : issue_b_rd;
  end

  // Single-entry units: a same-cycle issue overrides the retiring entry.
  for (genvar gi = 0; gi < 3; gi++) begin : g_unit
    logic          v_q;
    logic          wb_q;
    logic [RW-1:0] rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q  <= 1'b0;
        wb_q <= 1'b0;
        rd_q <= '0;
      end else if (iss_v[gi]) begin
        v_q  <= 1'b1;
        wb_q <= iss_wb[gi];
        rd_q <= iss_rd[gi];
      end else if (done_s[gi]) begin
        v_q  <= 1'b0;
      end
    end

    assign ent_mask[gi] = (v_q && wb_q) ? (NREGS'(1) << rd_q) : '0;

    a_occupied: assert property (@(posedge clk) disable iff (!rst_n)
      !(iss_v[gi] && v_q && !done_s[gi]));
    a_idle_done: assert property (@(posedge clk) disable iff (!rst_n)
      !(done_s[gi] && !v_q));
  end

  assign mask_alu_a  = ent_mask[0];
  assign mask_alu_b  = ent_mask[1];
  assign mask_branch = ent_mask[2];

  logic [PW-1:0]         head_q, tail_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [LDST_DEPTH-1:0] lv_q, lwb_q;
  logic [RW-1:0]         lrd_q [LDST_DEPTH];
  logic [NREGS-1:0]      lent_mask [LDST_DEPTH];
  logic                  push, pop;

  assign push = iss_v[3];
  assign pop  = done_ldst;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(LDST_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

  // Pop clears before push sets, so a full queue can pop and push one slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      lv_q   <= '0;
      lwb_q  <= '0;
      for (int i = 0; i < LDST_DEPTH; i++) lrd_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (pop) begin
        lv_q[head_q] <= 1'b0;
        head_q       <= ptr_inc(head_q);
      end
      if (push) begin
        lv_q[tail_q]  <= 1'b1;
        lwb_q[tail_q] <= iss_wb[3];
        lrd_q[tail_q] <= iss_rd[3];
        tail_q        <= ptr_inc(tail_q);
      end
    end
  end

  for (genvar gi = 0; gi < LDST_DEPTH; gi++) begin : g_lent
    assign lent_mask[gi] = (lv_q[gi] && lwb_q[gi]) ? (NREGS'(1) << lrd_q[gi]) : '0;
  end

  always_comb begin
    mask_ldst = '0;
    for (int i = 0; i < LDST_DEPTH; i++) mask_ldst = mask_ldst | lent_mask[i];
  end

  assign ldst_wait = (cnt_q == CW'(LDST_DEPTH));

  // Multiplier countdown: value 1 marks the writeback cycle.
  logic [MW-1:0] mcnt_q;
  logic          mwb_q;
  logic [RW-1:0] mrd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt_q <= '0;
      mwb_q  <= 1'b0;
      mrd_q  <= '0;
    end else if (iss_v[4]) begin
      mcnt_q <= MW'(MUL_LATENCY);
      mwb_q  <= iss_wb[4];
      mrd_q  <= iss_rd[4];
    end else if (mcnt_q != '0) begin
      mcnt_q <= mcnt_q - MW'(1);
    end
  end

  assign mul_busy     = (mcnt_q > MW'(1));
  assign mul_wb_valid = (mcnt_q == MW'(1));
  assign mul_wb_rd    = mrd_q;
  assign mask_mul     = ((mcnt_q != '0) && mwb_q) ? (NREGS'(1) << mrd_q) : '0;

  a_same_unit: assert property (@(posedge clk) disable iff (!rst_n)
    !(issue_a_valid && issue_b_valid && (issue_a_unit == issue_b_unit)));
  a_bad_unit_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(issue_a_valid && (issue_a_unit > 3'd4)));
  a_bad_unit_b: assert property (@(posedge clk) disable iff (!rst_n)
    !(issue_b_valid && (issue_b_unit > 3'd4)));
  a_ldst_over: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && ldst_wait));
  a_ldst_under: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && (cnt_q == '0)));
  a_mul_busy: assert property (@(posedge clk) disable iff (!rst_n)
    !(iss_v[4] && mul_busy));
endmodule
